spi_ram_arbiter: RTL
====================

# spi_ram_arbiter

Sits between the SPI slave and the single-port synchronous RAM. Decodes the slave's 10-bit command words (write-address, write-data, read-address, read-data), holds the latched addresses and shares the RAM port with a second, local requester. Arbitration is round-robin. RAM read data goes back to the SPI slave on `tx_data`/`tx_valid`, or to the local port on `loc_rdata`/`loc_rvalid`.

## Interface
- `ADDR_SIZE`, 8: RAM address width; RAM depth is 2^ADDR_SIZE.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `rx_data` input 10: SPI command word; [9:8] opcode, [7:0] payload.
- `rx_valid` input 1: one-cycle strobe, `rx_data` valid.
- `tx_data` output 8: read data to SPI slave.
- `tx_valid` output 1: one-cycle strobe, `tx_data` valid.
- `loc_req` input 1: local access request; level, held until `loc_gnt`.
- `loc_we` input 1: local request is a write (1) or read (0).
- `loc_addr` input ADDR_SIZE: local address.
- `loc_wdata` input 8: local write data.
- `loc_gnt` output 1: one-cycle pulse, local request issued to RAM.
- `loc_rdata` output 8: local read data.
- `loc_rvalid` output 1: one-cycle strobe, `loc_rdata` valid.
- `mem_en` output 1: RAM access enable.
- `mem_we` output 1: RAM write enable.
- `mem_addr` output ADDR_SIZE: RAM address.
- `mem_wdata` output 8: RAM write data.
- `mem_rdata` input 8: RAM read data, valid the cycle after a read access with `mem_en`=1.
- `spi_ovf` output 1: sticky; an SPI access command was dropped.

## Operation
- **Opcode decode** at the edge sampling `rx_valid`=1:
  - 00: `wr_addr` <= `rx_data[ADDR_SIZE-1:0]`.
  - 10: `rd_addr` <= `rx_data[ADDR_SIZE-1:0]`.
  - 01: enqueue write {`wr_addr`, `rx_data[7:0]`}.
  - 11: enqueue read {`rd_addr`}.
- **Address commands** (00/10) are accepted in every state.
- **SPI pending slot**: single entry. It stores a snapshot of address, data and rd/wr, so later 00/10 commands do not alter a queued access.
- **Overflow**: an enqueue while the slot is full and not being granted at that same edge is dropped and sets `spi_ovf`. `spi_ovf` clears only on reset.
- **FSM states**: IDLE, ACCESS, RD_DATA.
  - IDLE: if the SPI slot and/or `loc_req` is pending, grant one and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: `mem_en`=1 for exactly this cycle, with `mem_we`/`mem_addr`/`mem_wdata` from the granted requester. A write goes to IDLE; a read goes to RD_DATA.
  - RD_DATA: `mem_rdata` is valid. At the exit edge, capture it into `tx_data` (SPI) or `loc_rdata` (local), pulse the matching valid, and go to IDLE.
- **Round-robin**: a `last_gnt` bit resets to LOCAL, so SPI wins the first tie. When both are pending, grant the side not granted last. A lone requester is always granted.
- **Local handshake**: `loc_gnt` is high during the ACCESS cycle. The requester holds `loc_we`/`loc_addr`/`loc_wdata` stable from `loc_req` rise through `loc_gnt`. If `loc_req` is still high in the next IDLE, it is treated as a new request.
- The SPI slot clears at the edge entering ACCESS for an SPI grant.
- **Outputs**: all outputs are registered; no combinational path from input to output.

## Timing
- **Reset**: the edge sampling `rst_n`=0 clears all outputs, `wr_addr`, `rd_addr`, `last_gnt`, the slot and the FSM (to IDLE). An in-flight read is discarded; no valid strobe is produced.
- **SPI write**: `rx_valid`(01) in cycle 0 → slot full cycle 1 → `mem_en`/`mem_we` in cycle 2. This holds when uncontended.
- **SPI read**: `rx_valid`(11) in cycle 0 → `mem_en` in cycle 2 → `mem_rdata` in cycle 3 → `tx_valid` in cycle 4.
- **Local**: `loc_req` seen in IDLE at cycle k → `loc_gnt` and `mem_en` in cycle k+1. For reads, `loc_rvalid` follows in cycle k+3.
- **Throughput**:
  - Writes: one access per 2 cycles.
  - Reads: one access per 3 cycles.
  - Under contention, worst-case wait is one foreign access.
- `tx_valid`, `loc_rvalid` and `loc_gnt` are each exactly one cycle wide and never overlap for the same access.

## Test plan
- Reset, then `rx_data`=0x0_2A (00), then 0x1_5C (01) → `mem_en`=`mem_we`=1, `mem_addr`=0x2A, `mem_wdata`=0x5C, 2 cycles after the second `rx_valid`.
- `rx_data`=0x2_2A, then 0x3_00, with `mem_rdata`=0x5C in RD_DATA → `tx_valid`=1, `tx_data`=0x5C, 4 cycles after the read command.
- `loc_req`=1 (read, addr 0x10) held across the same cycle as an SPI write enqueue → SPI granted first (reset tie), then `loc_gnt`; repeat the tie → local granted first.
- Two SPI 01 commands 1 cycle apart while the local port holds a long read → second dropped, `spi_ovf`=1, only the first write reaches the RAM, with its snapshot address.
- 00 with new address while an SPI write is pending → RAM write uses the old address; the next write uses the new one.
- `rst_n`=0 during RD_DATA → no `tx_valid`, all outputs 0 next cycle, FSM in IDLE, `spi_ovf`=0.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
// Shares one single-port synchronous RAM between the SPI slave command stream
// and a local requester, using round-robin arbitration.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   rx_data, rx_valid     SPI command word ([9:8] opcode, [7:0] payload) + strobe
//   tx_data, tx_valid     SPI read data + one-cycle strobe
//   loc_req, loc_we,      local request (level, held until loc_gnt), write flag,
//   loc_addr, loc_wdata   address and write data
//   loc_gnt               one-cycle pulse while the local access is on the RAM port
//   loc_rdata, loc_rvalid local read data + one-cycle strobe
//   mem_en, mem_we,       RAM port (registered)
//   mem_addr, mem_wdata
//   mem_rdata             RAM read data, valid the cycle after a read access
//   spi_ovf               sticky: an SPI access command was dropped
//
// Opcodes: 00 set write address, 10 set read address,
//          01 enqueue write {wr_addr, payload}, 11 enqueue read {rd_addr}.

module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 loc_req,
  input  logic                 loc_we,
  input  logic [ADDR_SIZE-1:0] loc_addr,
  input  logic [7:0]           loc_wdata,
  output logic                 loc_gnt,
  output logic [7:0]           loc_rdata,
  output logic                 loc_rvalid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 spi_ovf
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_DATA} state_t;

  state_t state, state_nxt;

  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;

  // Single-entry SPI slot holding a snapshot of the queued access.
  logic                 slot_full;
  logic                 slot_we;
  logic [ADDR_SIZE-1:0] slot_addr;
  logic [7:0]           slot_data;

  // 1 = SPI was granted last, 0 = local was granted last (reset value).
  logic last_gnt_spi;
  // Owner and direction of the access currently in flight.
  logic cur_spi;
  logic cur_we;

  logic grant_spi, grant_loc;

  logic                 mem_en_d, mem_we_d, loc_gnt_d;
  logic [ADDR_SIZE-1:0] mem_addr_d;
  logic [7:0]           mem_wdata_d;
  logic                 tx_valid_d, loc_rvalid_d;

  logic enq, enq_is_wr;

  assign enq       = rx_valid && rx_data[8];
  assign enq_is_wr = !rx_data[9];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and arbitration. Grants are only decided in IDLE; on a tie the
  // side not granted last wins.
  always_comb begin
    grant_spi = 1'b0;
    grant_loc = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (slot_full && loc_req) begin
          grant_spi = !last_gnt_spi;
          grant_loc = last_gnt_spi;
        end else begin
          grant_spi = slot_full;
          grant_loc = loc_req;
        end
        if (grant_spi || grant_loc) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = cur_we ? IDLE : RD_DATA;
      RD_DATA: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next values for the registered outputs. The RAM port is
  // loaded at the edge entering ACCESS so mem_en is high for exactly that cycle.
  always_comb begin
    mem_en_d     = grant_spi || grant_loc;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    loc_gnt_d    = grant_loc;
    if (grant_spi) begin
      mem_we_d    = slot_we;
      mem_addr_d  = slot_addr;
      mem_wdata_d = slot_data;
    end else if (grant_loc) begin
      mem_we_d    = loc_we;
      mem_addr_d  = loc_addr;
      mem_wdata_d = loc_wdata;
    end
    tx_valid_d   = (state == RD_DATA) && cur_spi;
    loc_rvalid_d = (state == RD_DATA) && !cur_spi;
  end

  // Datapath: output registers, command decode, SPI slot and overflow flag.
  // An enqueue is accepted into a full slot only when that slot is being
  // granted at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      loc_gnt      <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      loc_rvalid   <= 1'b0;
      loc_rdata    <= '0;
      spi_ovf      <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      slot_full    <= 1'b0;
      slot_we      <= 1'b0;
      slot_addr    <= '0;
      slot_data    <= '0;
      last_gnt_spi <= 1'b0;
      cur_spi      <= 1'b0;
      cur_we       <= 1'b0;
    end else begin
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      loc_gnt    <= loc_gnt_d;
      tx_valid   <= tx_valid_d;
      loc_rvalid <= loc_rvalid_d;
      if (tx_valid_d)   tx_data   <= mem_rdata;
      if (loc_rvalid_d) loc_rdata <= mem_rdata;

      if (mem_en_d) begin
        cur_spi      <= grant_spi;
        cur_we       <= mem_we_d;
        last_gnt_spi <= grant_spi;
      end

      if (rx_valid) begin
        case (rx_data[9:8])
          2'b00:   wr_addr <= rx_data[ADDR_SIZE-1:0];
          2'b10:   rd_addr <= rx_data[ADDR_SIZE-1:0];
          default: ;
        endcase
      end

      if (grant_spi) slot_full <= 1'b0;
      if (enq) begin
        if (!slot_full || grant_spi) begin
          slot_full <= 1'b1;
          slot_we   <= enq_is_wr;
          slot_addr <= enq_is_wr ? wr_addr : rd_addr;
          slot_data <= enq_is_wr ? rx_data[7:0] : 8'h00;
        end else begin
          spi_ovf <= 1'b1;
        end
      end
    end
  end

endmodule
